// File: rtl/inst_feeder_if.sv
// Word-stream input plus instruction FIFO head/pop toward topcontrol.
interface inst_feeder_if #(
    parameter int unsigned INST_LEN = 220,
    parameter int unsigned WORD_LEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [WORD_LEN-1:0] in_data;
    logic [INST_LEN-1:0] instruct;
    logic                inst_empty;
    logic                inst_req;

    modport master (
        output in_valid, in_data, inst_req,
        input  in_ready, instruct, inst_empty
    );

    modport slave (
        input  in_valid, in_data, inst_req,
        output in_ready, instruct, inst_empty
    );
endinterface

// File: rtl/inst_feeder.sv
// Assembles fixed-length instructions from a 32-bit word stream into a small FIFO
// and counts out one program of inst_total instructions per start.
module inst_feeder #(
    parameter int unsigned INST_LEN   = 220,
    parameter int unsigned WORD_LEN   = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_LEN    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_LEN-1:0] inst_total,
    output logic               busy,
    output logic               done,
    inst_feeder_if.slave       bus
);
    localparam int unsigned WORDS = (INST_LEN + WORD_LEN - 1) / WORD_LEN;
    localparam int unsigned ASM_W = WORDS * WORD_LEN;
    localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW    = AW + 1;

    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
    localparam logic [PW-1:0]  FULL_OCC  = PW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state, state_n;
    logic [WCW-1:0]      word_cnt, word_cnt_n;
    logic [CNT_LEN-1:0]  remain_load, remain_load_n;
    logic [CNT_LEN-1:0]  remain_pop, remain_pop_n;
    logic [ASM_W-1:0]    asm_q, asm_n;
    logic [INST_LEN-1:0] push_data;
    logic [PW-1:0]       wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, occ_n;
    logic [INST_LEN-1:0] mem [FIFO_DEPTH];

    logic inst_req_d;
    logic in_ready_q, in_ready_n;
    logic busy_q, busy_n;
    logic done_q, done_n;
    logic fifo_empty, fifo_full;
    logic xfer, push, pop_evt, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (PW'(wr_ptr - rd_ptr) == FULL_OCC);

    // in_ready_q already folds in the full check, so a last-word transfer is always a legal push
    assign xfer    = bus.in_valid && in_ready_q;
    assign push    = xfer && (word_cnt == LAST_WORD);
    assign pop_evt = bus.inst_req && !inst_req_d;
    assign pop     = pop_evt && !fifo_empty;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_n       = state;
        word_cnt_n    = word_cnt;
        remain_load_n = remain_load;
        remain_pop_n  = pop ? (remain_pop - CNT_LEN'(1)) : remain_pop;
        asm_n         = asm_q;
        wr_ptr_n      = push ? (wr_ptr + PW'(1)) : wr_ptr;
        rd_ptr_n      = pop  ? (rd_ptr + PW'(1)) : rd_ptr;

        if (xfer) begin
            for (int k = 0; k < int'(WORDS); k++) begin
                if (word_cnt == WCW'(k)) begin
                    asm_n[k*WORD_LEN +: WORD_LEN] = bus.in_data;
                end
            end
            word_cnt_n = push ? '0 : (word_cnt + WCW'(1));
        end
        push_data = asm_n[INST_LEN-1:0];

        case (state)
            S_IDLE: begin
                if (start) begin
                    remain_load_n = inst_total;
                    remain_pop_n  = inst_total;
                    word_cnt_n    = '0;
                    state_n       = (inst_total == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (push) begin
                    remain_load_n = remain_load - CNT_LEN'(1);
                    if (remain_load == CNT_LEN'(1)) begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (remain_pop == '0) begin
                    state_n = S_DONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the post-edge values
        occ_n      = PW'(wr_ptr_n - rd_ptr_n);
        in_ready_n = (state_n == S_LOAD) && ((word_cnt_n != LAST_WORD) || (occ_n != FULL_OCC));
        busy_n     = (state_n == S_LOAD) || (state_n == S_DRAIN);
        done_n     = (state_n == S_DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counters, assembly register, FIFO storage and output flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt    <= '0;
            remain_load <= '0;
            remain_pop  <= '0;
            asm_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            inst_req_d  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            word_cnt    <= word_cnt_n;
            remain_load <= remain_load_n;
            remain_pop  <= remain_pop_n;
            asm_q       <= asm_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            inst_req_d  <= bus.inst_req;
            in_ready_q  <= in_ready_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.instruct   = mem[rd_ptr[AW-1:0]];
    assign bus.inst_empty = fifo_empty;
    assign busy           = busy_q;
    assign done           = done_q;

    // A pop request against an empty FIFO indicates a controller bug
    a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n) !(pop_evt && fifo_empty));
endmodule

// File: tb/tb_inst_feeder.sv
// Directed vectors and multi-cycle sequences for inst_feeder.
module tb_inst_feeder;
    localparam int unsigned INST_LEN = 220;
    localparam int unsigned WORD_LEN = 32;
    localparam int unsigned CNT_LEN  = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [CNT_LEN-1:0] inst_total;
    logic               busy;
    logic               done;

    inst_feeder_if #(.INST_LEN(INST_LEN), .WORD_LEN(WORD_LEN)) bus ();

    inst_feeder #(
        .INST_LEN(INST_LEN), .WORD_LEN(WORD_LEN), .FIFO_DEPTH(4), .CNT_LEN(CNT_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst_total(inst_total),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               start;
        logic [CNT_LEN-1:0] total;
        logic               valid;
        logic [31:0]        data;
        logic               req;
        logic               busy;
        logic               done;
        logic               rdy;
        logic               empty;
        logic               chk_inst;
        logic [INST_LEN-1:0] inst;
    } vec_t;

    vec_t tv [14];

    int checks = 0;
    int errors = 0;

    logic                req_prev = 1'b0;
    logic                xfer_seen, popped, done_seen, busy_seen;
    logic [INST_LEN-1:0] head;
    logic [31:0]         seed;
    int                  wi, pop_idx, coin, tail;

    task automatic chk(input string name, input logic [INST_LEN-1:0] act, input logic [INST_LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic s, input logic [CNT_LEN-1:0] t, input logic v,
                                 input logic [31:0] d, input logic r, input logic b, input logic dn,
                                 input logic rd, input logic e, input logic ci,
                                 input logic [INST_LEN-1:0] inst);
        vec_t x;
        x.start = s; x.total = t; x.valid = v; x.data = d; x.req = r;
        x.busy = b; x.done = dn; x.rdy = rd; x.empty = e; x.chk_inst = ci; x.inst = inst;
        return x;
    endfunction

    // Expected instruction idx of a program whose word n is seed + n
    function automatic logic [INST_LEN-1:0] mk_inst(input logic [31:0] s, input int idx);
        logic [7*32-1:0] r;
        for (int k = 0; k < 7; k++) r[k*32 +: 32] = s + 32'(idx * 7 + k);
        return r[INST_LEN-1:0];
    endfunction

    function automatic logic [31:0] wd(input logic [31:0] s, input int n);
        return s + 32'(n);
    endfunction

    // One clock: drive, sample pre-edge at negedge, return 1 time unit after posedge
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.inst_req = r;
        @(negedge clk);
        xfer_seen = v && bus.in_ready;
        popped    = r && !req_prev && !bus.inst_empty;
        head      = bus.instruct;
        done_seen = done;
        busy_seen = busy;
        req_prev  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop(input string name);
        if (popped) begin
            chk(name, head, mk_inst(seed, pop_idx));
            pop_idx++;
        end
    endtask

    task automatic do_start(input logic [CNT_LEN-1:0] t);
        start      = 1'b1;
        inst_total = t;
        cyc(1'b0, 32'd0, 1'b0);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int found;
        found = 0;
        for (int c = 0; c < bound && found == 0; c++) begin
            cyc(1'b0, 32'd0, 1'b0);
            if (done_seen) found = 1;
        end
        chki({name, "_done_seen"}, found, 1);
        chki({name, "_busy_at_done"}, int'(busy_seen), 0);
    endtask

    initial begin
        logic [INST_LEN-1:0] t1;
        logic                r;
        t1 = 220'h0000007_00000006_00000005_00000004_00000003_00000002_00000001;

        // Test 1: single instruction, pop, done; then zero-length program and start-during-done
        tv[0] = mkv(1'b1, 16'd1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 6; k++)
            tv[k] = mkv(1'b0, 16'd0, 1'b1, 32'(k), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        tv[7]  = mkv(1'b0, 16'd0, 1'b1, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, t1);
        tv[8]  = mkv(1'b0, 16'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tv[9]  = mkv(1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tv[10] = mkv(1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tv[11] = mkv(1'b1, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tv[12] = mkv(1'b1, 16'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tv[13] = mkv(1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        rst_n = 1'b0; start = 1'b0; inst_total = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.inst_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_in_ready", int'(bus.in_ready), 0);
        chki("rst_inst_empty", int'(bus.inst_empty), 1);
        chk("rst_instruct", bus.instruct, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            start      = tv[i].start;
            inst_total = tv[i].total;
            cyc(tv[i].valid, tv[i].data, tv[i].req);
            chki($sformatf("vec%0d_busy", i), int'(busy), int'(tv[i].busy));
            chki($sformatf("vec%0d_done", i), int'(done), int'(tv[i].done));
            chki($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(tv[i].rdy));
            chki($sformatf("vec%0d_inst_empty", i), int'(bus.inst_empty), int'(tv[i].empty));
            if (tv[i].chk_inst) chk($sformatf("vec%0d_instruct", i), bus.instruct, tv[i].inst);
        end
        start = 1'b0;

        // Test 2: fill until the last word of instruction 5 stalls, then release it with one pop
        seed = 32'h1000_0000; wi = 0; pop_idx = 0;
        do_start(16'd6);
        for (int c = 0; c < 40; c++) begin
            cyc(wi < 42, wd(seed, wi), 1'b0);
            if (xfer_seen) wi++;
        end
        chki("t2_words_before_stall", wi, 34);
        chki("t2_stall_in_ready", int'(bus.in_ready), 0);
        chki("t2_stall_nonempty", int'(bus.inst_empty), 0);
        cyc(1'b1, wd(seed, wi), 1'b1);
        check_pop("t2_pop_head");
        chki("t2_no_xfer_in_pop_cycle", int'(xfer_seen), 0);
        chki("t2_in_ready_after_pop", int'(bus.in_ready), 1);
        cyc(1'b1, wd(seed, wi), 1'b0);
        chki("t2_held_word_accepted", int'(xfer_seen), 1);
        if (xfer_seen) wi++;
        for (int c = 0; c < 300 && pop_idx < 6; c++) begin
            r = !req_prev && !bus.inst_empty;
            cyc(wi < 42, wd(seed, wi), r);
            if (xfer_seen) wi++;
            check_pop("t2_pop_order");
        end
        chki("t2_total_words", wi, 42);
        chki("t2_total_pops", pop_idx, 6);
        wait_done("t2", 10);

        // Test 3: inst_req held high pops exactly once
        seed = 32'h2000_0000; wi = 0; pop_idx = 0;
        do_start(16'd3);
        for (int c = 0; c < 40 && wi < 21; c++) begin
            cyc(1'b1, wd(seed, wi), 1'b0);
            if (xfer_seen) wi++;
        end
        chki("t3_words", wi, 21);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 32'd0, 1'b1);
            check_pop("t3_held_pop_head");
        end
        chki("t3_single_pop", pop_idx, 1);
        chk("t3_head_after_hold", bus.instruct, mk_inst(seed, 1));
        cyc(1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1);
        check_pop("t3_second_pop");
        chki("t3_one_left", int'(bus.inst_empty), 0);
        cyc(1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1);
        check_pop("t3_third_pop");
        chki("t3_empty_after_three", int'(bus.inst_empty), 1);
        chki("t3_total_pops", pop_idx, 3);
        wait_done("t3", 10);

        // Test 4: push and pop in the same cycle at occupancy 2, pointers wrap
        seed = 32'h3000_0000; wi = 0; pop_idx = 0; coin = 0; tail = 0;
        do_start(16'd8);
        for (int c = 0; c < 200 && wi < 56; c++) begin
            r = (wi % 7 == 6) && (wi >= 20) && !req_prev;
            cyc(1'b1, wd(seed, wi), r);
            if (xfer_seen && popped) coin++;
            if (xfer_seen) wi++;
            check_pop("t4_pop_order");
        end
        chki("t4_words", wi, 56);
        chki("t4_coincident", coin, 6);
        chki("t4_not_empty", int'(bus.inst_empty), 0);
        for (int c = 0; c < 20 && !bus.inst_empty; c++) begin
            r = !req_prev;
            cyc(1'b0, 32'd0, r);
            if (popped) tail++;
            check_pop("t4_tail_order");
        end
        chki("t4_occupancy_left", tail, 2);
        wait_done("t4", 10);

        // Test 6: reset mid-program discards everything, next program starts clean
        seed = 32'h4000_0000; wi = 0;
        do_start(16'd2);
        for (int c = 0; c < 30 && wi < 10; c++) begin
            cyc(1'b1, wd(seed, wi), 1'b0);
            if (xfer_seen) wi++;
        end
        chki("t6_partial_words", wi, 10);
        rst_n = 1'b0;
        cyc(1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;
        chki("t6_rst_empty", int'(bus.inst_empty), 1);
        chki("t6_rst_busy", int'(busy), 0);
        chki("t6_rst_in_ready", int'(bus.in_ready), 0);
        chk("t6_rst_instruct", bus.instruct, '0);
        seed = 32'h5000_0000; wi = 0; pop_idx = 0;
        do_start(16'd1);
        for (int c = 0; c < 20 && wi < 7; c++) begin
            cyc(1'b1, wd(seed, wi), 1'b0);
            if (xfer_seen) wi++;
        end
        chk("t6_clean_instruct", bus.instruct, mk_inst(seed, 0));
        chki("t6_nonempty", int'(bus.inst_empty), 0);
        cyc(1'b0, 32'd0, 1'b1);
        check_pop("t6_pop");
        chki("t6_pops", pop_idx, 1);
        wait_done("t6", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
